// File: rtl/mc_isa_pkg.sv
// Shared ISA definitions for the multicycle CPU control path: opcodes,
// ALU operation codes, PC/writeback mux encodings and FSM state codes.
package mc_isa_pkg;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_NOT  = 6'b010001;
  localparam logic [5:0] OP_ADD  = 6'b010010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_OR   = 6'b010100;
  localparam logic [5:0] OP_AND  = 6'b010101;
  localparam logic [5:0] OP_XOR  = 6'b010110;
  localparam logic [5:0] OP_SLT  = 6'b010111;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b100001;
  localparam logic [5:0] OP_BLT  = 6'b100010;
  localparam logic [5:0] OP_BLE  = 6'b100011;
  localparam logic [5:0] OP_ADDI = 6'b110010;
  localparam logic [5:0] OP_SUBI = 6'b110011;
  localparam logic [5:0] OP_ORI  = 6'b110100;
  localparam logic [5:0] OP_ANDI = 6'b110101;
  localparam logic [5:0] OP_XORI = 6'b110110;
  localparam logic [5:0] OP_SLTI = 6'b110111;
  localparam logic [5:0] OP_LI   = 6'b111001;
  localparam logic [5:0] OP_LUI  = 6'b111010;
  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_SWI  = 6'b111100;
  localparam logic [5:0] OP_LW   = 6'b111101;
  localparam logic [5:0] OP_SW   = 6'b111110;

  // ALU operations
  localparam logic [2:0] ALU_MOV = 3'd0;
  localparam logic [2:0] ALU_NOT = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_AND = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // PC source select
  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_HOLD = 2'd2;

  // Writeback select
  localparam logic [1:0] WB_ALU_OUT  = 2'd0;
  localparam logic [1:0] WB_MEM_DATA = 2'd1;
  localparam logic [1:0] WB_LI_VAL   = 2'd2;
  localparam logic [1:0] WB_LUI_VAL  = 2'd3;

  // FSM state codes (plain constants so older tools can consume them)
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_WB_ALU = 4'd4;
  localparam logic [3:0] S_WB_IMM = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BR_CMP = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  // Zero-based addressing (LWI/SWI) forces ALU operand A to zero
  function automatic logic is_base_zero(input logic [5:0] op);
    return (op == OP_LWI) || (op == OP_SWI);
  endfunction

endpackage

// File: rtl/mc_branch_eval.sv
// Branch condition evaluation: opcode[1:0] selects BEQ/BNE/BLT/BLE.
module mc_branch_eval (
  input  logic [1:0] br_sel,
  input  logic       cmp_zero,
  input  logic       cmp_neg,
  output logic       taken
);

  // Condition select from the low opcode bits
  always_comb begin
    taken = 1'b0;
    case (br_sel)
      2'b00:   taken = cmp_zero;
      2'b01:   taken = !cmp_zero;
      2'b10:   taken = cmp_neg;
      default: taken = cmp_neg | cmp_zero;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU main control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes, resolves branches and counts retires.
module mc_control_fsm
  import mc_isa_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             cmp_zero,
  input  logic             cmp_neg,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic             base_zero,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             br_taken;
  logic             is_store;

  mc_branch_eval u_br (
    .br_sel   (opcode[1:0]),
    .cmp_zero (cmp_zero),
    .cmp_neg  (cmp_neg),
    .taken    (br_taken)
  );

  assign is_store = (opcode[5:0] == OP_SWI) || (opcode[5:0] == OP_SW);

  // Next-state selection; also flags the last cycle of each legal instruction
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        casez (opcode[5:0])
          6'b010???, 6'b110???:            state_d = S_EXEC;
          OP_LI, OP_LUI:                   state_d = S_WB_IMM;
          OP_LWI, OP_LW, OP_SWI, OP_SW:    state_d = S_ADDR;
          6'b1000??:                       state_d = S_BR_CMP;
          OP_J:                            state_d = S_JUMP;
          OP_NOP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_d = S_WB_ALU;
      S_ADDR:   state_d = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_WB_ALU, S_WB_IMM, S_WB_MEM, S_BR_CMP, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state (pc_write in BR_CMP
  // additionally follows the branch flags)
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_HOLD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU_OUT;
    alu_src_b = 1'b0;
    base_zero = 1'b0;
    alu_op    = ALU_MOV;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_SEQ;
      end
      S_EXEC: begin
        alu_op    = opcode[2:0];
        alu_src_b = opcode[5];
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        alu_op    = opcode[2:0];
        alu_src_b = opcode[5];
      end
      S_WB_IMM: begin
        reg_write = 1'b1;
        wb_sel    = (opcode[5:0] == OP_LI) ? WB_LI_VAL : WB_LUI_VAL;
      end
      S_ADDR, S_MEM_RD, S_MEM_WR: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
        base_zero = is_base_zero(opcode[5:0]);
        mem_read  = (state_q == S_MEM_RD);
        mem_write = (state_q == S_MEM_WR);
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM_DATA;
      end
      S_BR_CMP: begin
        alu_op   = ALU_SUB;
        pc_write = br_taken;
        if (br_taken) pc_src = PC_BR;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_BR;
      end
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_comb cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state         = state_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, random instruction
// stream against an instruction-level reference model, reset corner cases.
module tb_mc_control_fsm;
  import mc_isa_pkg::*;

  localparam int CW = 4;  // narrow counter so wrap-around is reached

  logic clk = 1'b0;
  logic rst_n, run, cmp_zero, cmp_neg, mem_ready;
  logic [5:0] opcode;
  logic ir_write, pc_write, reg_write, alu_src_b, base_zero;
  logic mem_read, mem_write, illegal_op;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [CW-1:0] instr_retired;

  mc_control_fsm #(.CNT_W(CW), .OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .cmp_zero(cmp_zero), .cmp_neg(cmp_neg), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .base_zero(base_zero), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .illegal_op(illegal_op), .state(state),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt;

  // Per-instruction summary: cycle count from FETCH and event counts
  typedef struct {
    int len, rw, wbsel, alu, nrd, nwr, nbz, npcw, nill, ret;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    int         waits;
    logic       z, n;
    exp_t       e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Instruction-level reference: what one instruction does in total
  function automatic exp_t model(input logic [5:0] op, input int w, input logic z, input logic n);
    exp_t e;
    logic tk;
    e = '{default: 0};
    e.npcw = 1;
    tk = 1'b0;
    if (op == 6'b000000) begin
      e.len = 2; e.ret = 1;
    end else if (op == 6'b000001) begin
      e.len = 3; e.npcw = 2; e.ret = 1;
    end else if (op[5:3] == 3'b010 || op[5:3] == 3'b110) begin
      e.len = 4; e.rw = 1; e.wbsel = 0; e.alu = int'(op[2:0]); e.ret = 1;
    end else if (op == 6'b111001 || op == 6'b111010) begin
      e.len = 3; e.rw = 1; e.wbsel = (op == 6'b111001) ? 2 : 3; e.ret = 1;
    end else if (op == 6'b111011 || op == 6'b111101) begin
      e.len = 5 + w; e.rw = 1; e.wbsel = 1; e.nrd = w + 1; e.ret = 1;
      e.nbz = (op == 6'b111011) ? w + 2 : 0;
    end else if (op == 6'b111100 || op == 6'b111110) begin
      e.len = 4 + w; e.nwr = w + 1; e.ret = 1;
      e.nbz = (op == 6'b111100) ? w + 2 : 0;
    end else if (op[5:2] == 4'b1000) begin
      case (op[1:0])
        2'd0: tk = z;
        2'd1: tk = !z;
        2'd2: tk = n;
        default: tk = n || z;
      endcase
      e.len = 3; e.npcw = tk ? 2 : 1; e.ret = 1;
    end else begin
      e.len = 2; e.nill = 1;
    end
    return e;
  endfunction

  // Runs one instruction starting mid-cycle in FETCH; returns mid-cycle in the next FETCH
  task automatic exec(input int idx, input vec_t v);
    int c, rw, wbs, alu, nrd, nwr, nbz, npcw, nsrc1, nill, nir;
    logic done;
    rw = 0; wbs = 0; alu = 0; nrd = 0; nwr = 0; nbz = 0;
    npcw = 0; nsrc1 = 0; nill = 0; nir = 0; done = 1'b0;
    opcode = v.op; cmp_zero = v.z; cmp_neg = v.n;
    mem_ready = (v.waits == 0);
    #1;
    chk($sformatf("v%0d.start_state", idx), state, S_FETCH);
    c = 0;
    while (c < 40) begin
      if (c > 0 && state == S_FETCH) begin
        done = 1'b1;
        break;
      end
      if (reg_write) begin rw++; wbs = int'(wb_sel); alu = int'(alu_op); end
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (base_zero) nbz++;
      if (pc_write) npcw++;
      if (pc_write && pc_src == 2'd1) nsrc1++;
      if (illegal_op) nill++;
      if (ir_write) nir++;
      c++;
      @(negedge clk);
      mem_ready = ((nrd + nwr) >= v.waits);
      #1;
    end
    chk($sformatf("v%0d.op%b.finished", idx, v.op), done, 1'b1);
    chk($sformatf("v%0d.op%b.len", idx, v.op), c, v.e.len);
    chk($sformatf("v%0d.reg_write_cycles", idx), rw, v.e.rw);
    if (v.e.rw > 0) chk($sformatf("v%0d.wb_sel", idx), wbs, v.e.wbsel);
    if (v.e.rw > 0 && v.e.wbsel == 0) chk($sformatf("v%0d.alu_op", idx), alu, v.e.alu);
    chk($sformatf("v%0d.mem_read_cycles", idx), nrd, v.e.nrd);
    chk($sformatf("v%0d.mem_write_cycles", idx), nwr, v.e.nwr);
    chk($sformatf("v%0d.base_zero_cycles", idx), nbz, v.e.nbz);
    chk($sformatf("v%0d.pc_write_cycles", idx), npcw, v.e.npcw);
    chk($sformatf("v%0d.pc_src1_cycles", idx), nsrc1, v.e.npcw - 1);
    chk($sformatf("v%0d.illegal_cycles", idx), nill, v.e.nill);
    chk($sformatf("v%0d.ir_write_cycles", idx), nir, 1);
    exp_cnt = exp_cnt + CW'(v.e.ret);
    chk($sformatf("v%0d.instr_retired", idx), instr_retired, exp_cnt);
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    // op, waits, z, n, {len, rw, wbsel, alu, nrd, nwr, nbz, npcw, nill, ret}
    tbl[0]  = '{6'b010010, 0, 1'b0, 1'b0, '{4, 1, 0, 2, 0, 0, 0, 1, 0, 1}}; // ADD
    tbl[1]  = '{6'b111011, 3, 1'b0, 1'b0, '{8, 1, 1, 0, 4, 0, 5, 1, 0, 1}}; // LWI, 3 waits
    tbl[2]  = '{6'b100001, 0, 1'b0, 1'b0, '{3, 0, 0, 0, 0, 0, 0, 2, 0, 1}}; // BNE taken
    tbl[3]  = '{6'b100001, 0, 1'b1, 1'b0, '{3, 0, 0, 0, 0, 0, 0, 1, 0, 1}}; // BNE not taken
    tbl[4]  = '{6'b100011, 0, 1'b1, 1'b0, '{3, 0, 0, 0, 0, 0, 0, 2, 0, 1}}; // BLE on zero
    tbl[5]  = '{6'b100010, 0, 1'b0, 1'b1, '{3, 0, 0, 0, 0, 0, 0, 2, 0, 1}}; // BLT taken
    tbl[6]  = '{6'b100000, 0, 1'b0, 1'b1, '{3, 0, 0, 0, 0, 0, 0, 1, 0, 1}}; // BEQ not taken
    tbl[7]  = '{6'b101010, 0, 1'b0, 1'b0, '{2, 0, 0, 0, 0, 0, 0, 1, 1, 0}}; // illegal
    tbl[8]  = '{6'b000000, 0, 1'b0, 1'b0, '{2, 0, 0, 0, 0, 0, 0, 1, 0, 1}}; // NOP
    tbl[9]  = '{6'b111001, 0, 1'b0, 1'b0, '{3, 1, 2, 0, 0, 0, 0, 1, 0, 1}}; // LI
    tbl[10] = '{6'b111010, 0, 1'b0, 1'b0, '{3, 1, 3, 0, 0, 0, 0, 1, 0, 1}}; // LUI
    tbl[11] = '{6'b111110, 2, 1'b0, 1'b0, '{6, 0, 0, 0, 0, 3, 0, 1, 0, 1}}; // SW, 2 waits
    tbl[12] = '{6'b111100, 0, 1'b0, 1'b0, '{4, 0, 0, 0, 0, 1, 2, 1, 0, 1}}; // SWI
    tbl[13] = '{6'b111101, 1, 1'b0, 1'b0, '{6, 1, 1, 0, 2, 0, 0, 1, 0, 1}}; // LW, 1 wait
    tbl[14] = '{6'b000001, 0, 1'b0, 1'b0, '{3, 0, 0, 0, 0, 0, 0, 2, 0, 1}}; // J
    tbl[15] = '{6'b110110, 0, 1'b0, 1'b0, '{4, 1, 0, 6, 0, 0, 0, 1, 0, 1}}; // XORI

    rst_n = 1'b0; run = 1'b1; opcode = 6'b0;
    cmp_zero = 1'b0; cmp_neg = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    #1;
    chk("reset.state", state, S_IDLE);
    chk("reset.strobes", {ir_write, pc_write, reg_write, mem_read, mem_write,
                          illegal_op, base_zero, alu_src_b}, 0);
    chk("reset.pc_src", pc_src, 2);
    chk("reset.wb_sel", wb_sel, 0);
    chk("reset.alu_op", alu_op, 0);
    chk("reset.instr_retired", instr_retired, 0);
    rst_n = 1'b1;
    #1 chk("release.idle_cycle", state, S_IDLE);
    @(negedge clk); #1;
    chk("release.fetch", state, S_FETCH);

    // Directed table
    for (int i = 0; i < 16; i++) exec(i, tbl[i]);

    // Random stream; run toggles freely since it only matters in IDLE
    for (int i = 0; i < 150; i++) begin
      do rv.op = 6'($urandom_range(0, 63));
      while (rv.op[5:2] == 4'b0101 || rv.op[5:2] == 4'b1101);
      rv.waits = $urandom_range(0, 3);
      rv.z = 1'($urandom);
      rv.n = 1'($urandom);
      rv.e = model(rv.op, rv.waits, rv.z, rv.n);
      run = 1'($urandom);
      exec(100 + i, rv);
    end

    // Asynchronous reset in the middle of a store wait
    opcode = 6'b111110; mem_ready = 1'b0; run = 1'b1;
    for (int c = 0; c < 10 && !mem_write; c++) begin
      @(negedge clk); #1;
    end
    chk("abort.reached_mem_wr", mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.mem_write_drop", mem_write, 1'b0);
    chk("abort.state_idle", state, S_IDLE);
    chk("abort.counter_cleared", instr_retired, 0);
    exp_cnt = '0;
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("abort.waits_for_run", state, S_IDLE);
    run = 1'b1;
    @(negedge clk); #1;
    chk("abort.restart_fetch", state, S_FETCH);
    rv.op = 6'b000000; rv.waits = 0; rv.z = 1'b0; rv.n = 1'b0;
    rv.e = model(rv.op, 0, 1'b0, 1'b0);
    exec(999, rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
